// File: rtl/pi_limit_multi_channel.sv
// Time-multiplexed PI controller with output limiting for NCH channels (3-stage pipeline).
// Define PI_MC_ANTIWINDUP_EN to clamp each stored integrator to [LOWER, UPPER].
module pi_limit_multi_channel #(
  parameter int WIDTH = 32,
  parameter int FRAC = 16,
  parameter int NCH = 4,
  parameter logic signed [WIDTH-1:0] KP = 32'sh0000_8000,
  parameter logic signed [WIDTH-1:0] KI_DT2 = 32'sh0000_4000,
  parameter logic signed [WIDTH-1:0] UPPER = 32'sh0001_8000,
  parameter logic signed [WIDTH-1:0] LOWER = 32'shFFFE_8000,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rst_user,
  input  logic                    sta,
  input  logic                    x_valid,
  input  logic signed [WIDTH-1:0] x,
  output logic signed [WIDTH-1:0] y,
  output logic                    y_valid,
  output logic [CH_W-1:0]         y_ch,
  output logic                    busy,
  output logic                    done_sig
);

  localparam int PW = 2 * WIDTH + 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);
  localparam logic signed [PW-1:0] MAX_PW = {{(WIDTH + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_PW = {{(WIDTH + 2){1'b1}}, {(WIDTH - 1){1'b0}}};
  localparam logic signed [WIDTH:0] UPPER_X = {UPPER[WIDTH-1], UPPER};
  localparam logic signed [WIDTH:0] LOWER_X = {LOWER[WIDTH-1], LOWER};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [PW-1:0] v);
    if (v > MAX_PW) return MAX_PW[WIDTH-1:0];
    if (v < MIN_PW) return MIN_PW[WIDTH-1:0];
    return v[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] clamp_lim(input logic signed [WIDTH:0] v);
    if (v > UPPER_X) return UPPER;
    if (v < LOWER_X) return LOWER;
    return v[WIDTH-1:0];
  endfunction

  function automatic logic signed [PW-1:0] sext_pw(input logic signed [WIDTH:0] v);
    return {{WIDTH{v[WIDTH]}}, v};
  endfunction

  state_t state, state_nx;
  logic [CH_W-1:0] ch_cnt;
  logic accept, last_ch, pipe_empty;

  logic signed [WIDTH-1:0] integ [NCH];
  logic signed [WIDTH-1:0] xprev [NCH];

  logic signed [WIDTH-1:0] xp_rd, p_s1, d_s1;
  logic signed [WIDTH:0]   x_w, xsum;
  logic signed [PW-1:0]    p_full, d_full, p_sh, d_sh;

  logic                    vld_p0, vld_p1;
  logic signed [WIDTH-1:0] p_p0, d_p0, x_p0, p_p1, i_p1;
  logic [CH_W-1:0]         ch_p0, ch_p1;

  logic signed [WIDTH-1:0] i_rd, i_sat, i_new, y_lim;
  logic signed [WIDTH:0]   isum, ysum;

  assign accept     = (state == RUN) && x_valid;
  assign last_ch    = (ch_cnt == LAST_CH);
  assign pipe_empty = !vld_p0 && !vld_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (rst_user) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (sta) state_nx = RUN;
        RUN:     if (accept && last_ch) state_nx = DRAIN;
        DRAIN:   if (pipe_empty) state_nx = DONE;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // busy drops in the DONE cycle so it falls together with the done pulse
  always_comb begin
    busy     = (state == RUN) || (state == DRAIN);
    done_sig = (state == DONE);
  end

  // Stage 1: proportional term and trapezoidal integrator increment
  assign xp_rd  = xprev[ch_cnt];
  assign x_w    = {x[WIDTH-1], x};
  assign xsum   = x_w + {xp_rd[WIDTH-1], xp_rd};
  assign p_full = sext_pw(x_w) * sext_pw({KP[WIDTH-1], KP});
  assign d_full = sext_pw(xsum) * sext_pw({KI_DT2[WIDTH-1], KI_DT2});
  assign p_sh   = p_full >>> FRAC;
  assign d_sh   = d_full >>> FRAC;
  assign p_s1   = sat_w(p_sh);
  assign d_s1   = sat_w(d_sh);

  // Stage 2: integrator update
  assign i_rd  = integ[ch_p0];
  assign isum  = {i_rd[WIDTH-1], i_rd} + {d_p0[WIDTH-1], d_p0};
  assign i_sat = sat_w(sext_pw(isum));
`ifdef PI_MC_ANTIWINDUP_EN
  assign i_new = clamp_lim({i_sat[WIDTH-1], i_sat});
`else
  assign i_new = i_sat;
`endif

  // Stage 3: output sum and limit
  assign ysum  = {p_p1[WIDTH-1], p_p1} + {i_p1[WIDTH-1], i_p1};
  assign y_lim = clamp_lim(ysum);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_cnt  <= '0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      y_valid <= 1'b0;
      y       <= '0;
      y_ch    <= '0;
    end else if (rst_user) begin
      ch_cnt  <= '0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      vld_p0  <= accept;
      vld_p1  <= vld_p0;
      y_valid <= vld_p1;
      if (accept) ch_cnt <= last_ch ? '0 : ch_cnt + CH_W'(1);
      if (vld_p1) begin
        y    <= y_lim;
        y_ch <= ch_p1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        integ[c] <= '0;
        xprev[c] <= '0;
      end
    end else if (rst_user) begin
      for (int c = 0; c < NCH; c++) begin
        integ[c] <= '0;
        xprev[c] <= '0;
      end
    end else if (vld_p0) begin
      integ[ch_p0] <= i_new;
      xprev[ch_p0] <= x_p0;
    end
  end

  always_ff @(posedge clk) begin
    p_p0  <= p_s1;
    d_p0  <= d_s1;
    x_p0  <= x;
    ch_p0 <= ch_cnt;
    p_p1  <= p_p0;
    i_p1  <= i_new;
    ch_p1 <= ch_p0;
  end

endmodule

// File: tb/tb_pi_limit_multi_channel.sv
// Bench for pi_limit_multi_channel: scenario tasks against an arithmetic reference model.
// Honours PI_MC_ANTIWINDUP_EN the same way the design does.
module tb_pi_limit_multi_channel;
  localparam int W = 32;
  localparam int F = 16;
  localparam int N = 4;
  localparam longint KP_V  = 64'sd32768;
  localparam longint KI_V  = 64'sd16384;
  localparam longint UP_V  = 64'sd98304;
  localparam longint LO_V  = -64'sd98304;
  localparam longint MAX_V = 64'sd2147483647;
  localparam longint MIN_V = -64'sd2147483648;
  localparam longint ONE_V = 64'sd65536;
  localparam logic [W-1:0] SENT = 32'hDEAD_BEEF;

  typedef struct { int at; int ch; logic [W-1:0] yv; } exp_t;
  typedef struct { bit s; bit v; bit ru; bit acc; logic [W-1:0] xv; } cyc_t;
  typedef longint frame_t [N];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_user = 1'b0, sta = 1'b0, x_valid = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y;
  logic y_valid, busy, done_sig;
  logic [1:0] y_ch;

  pi_limit_multi_channel dut (
    .clk(clk), .rst(rst), .rst_user(rst_user), .sta(sta), .x_valid(x_valid), .x(x),
    .y(y), .y_valid(y_valid), .y_ch(y_ch), .busy(busy), .done_sig(done_sig)
  );

  always #5 clk = ~clk;

  exp_t exq[$];
  longint m_i [N];
  longint m_xp [N];
  logic [W-1:0] obs_y [N];
  logic [W-1:0] y_hold = '0;
  logic busy_exp = 1'b0;
  int n = 0, done_at = -1, done_seen = 0;
  int checks = 0, errors = 0;

  function automatic longint sat(longint v);
    return (v > MAX_V) ? MAX_V : ((v < MIN_V) ? MIN_V : v);
  endfunction

  function automatic longint lim(longint v);
    return (v > UP_V) ? UP_V : ((v < LO_V) ? LO_V : v);
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < N; c++) begin
      m_i[c] = 0;
      m_xp[c] = 0;
    end
  endfunction

  // PI law on plain integers: floor-shifted products, saturating integrator, limited sum
  function automatic longint model_step(int ch, longint xv);
    longint p, d, inew;
    p = sat((KP_V * xv) >>> F);
    d = sat((KI_V * (xv + m_xp[ch])) >>> F);
    inew = sat(m_i[ch] + d);
`ifdef PI_MC_ANTIWINDUP_EN
    inew = lim(inew);
`endif
    m_i[ch] = inew;
    m_xp[ch] = xv;
    return lim(p + inew);
  endfunction

  function automatic longint rand_x();
    case ($urandom_range(0, 3))
      0: return longint'($urandom_range(0, 262144)) - 64'sd131072;
      1: return longint'($signed($urandom));
      2: return ($urandom_range(0, 1) == 1) ? MAX_V : MIN_V;
      default: return longint'($urandom_range(0, 1024)) - 64'sd512 +
                      (($urandom_range(0, 1) == 1) ? UP_V : LO_V);
    endcase
  endfunction

  function automatic cyc_t mk(bit s, bit v, bit ru, bit acc, logic [W-1:0] xv);
    cyc_t c;
    c.s = s; c.v = v; c.ru = ru; c.acc = acc; c.xv = xv;
    return c;
  endfunction

  function automatic void clear_obs();
    foreach (obs_y[i]) obs_y[i] = SENT;
  endfunction

  // Drives one frame cycle by cycle and compares every output each cycle.
  task automatic run_frame(input frame_t xs, input int gap_max, input bit noise, input int abort_ch);
    cyc_t plan[$];
    cyc_t c;
    int ch, start_idx, exp_ch;
    bit exp_v;
    logic [W-1:0] exp_y;
    ch = 0;
    if (noise) repeat ($urandom_range(0, 2)) plan.push_back(mk(0, 1, 0, 0, $urandom));
    start_idx = plan.size();
    plan.push_back(mk(1, 0, 0, 0, '0));
    for (int k = 0; k < N; k++) begin
      repeat ($urandom_range(0, gap_max))
        plan.push_back(mk(noise && ($urandom_range(0, 1) == 1), 0, 0, 0, $urandom));
      plan.push_back(mk(0, 1, 0, 1, xs[k][W-1:0]));
      if (k == abort_ch) begin
        plan.push_back(mk(1, 1, 1, 0, $urandom));
        break;
      end
    end
    repeat (6) plan.push_back(mk(0, noise, 0, 0, $urandom));

    for (int i = 0; i < plan.size(); i++) begin
      c = plan[i];
      sta = c.s; x_valid = c.v; rst_user = c.ru; x = c.xv;
      @(posedge clk);
      n++;
      if (i == start_idx) busy_exp = 1'b1;
      if (c.acc) begin
        exq.push_back('{at: n + 2, ch: ch, yv: 32'(model_step(ch, longint'($signed(c.xv))))});
        if (ch == N - 1) done_at = n + 3;
        ch++;
      end
      if (c.ru) begin
        model_clear();
        while (exq.size() > 0 && exq[exq.size() - 1].at >= n) void'(exq.pop_back());
        done_at = -1;
        busy_exp = 1'b0;
      end
      #1;
      exp_v = 1'b0; exp_y = y_hold; exp_ch = -1;
      if (exq.size() > 0 && exq[0].at == n) begin
        exp_v = 1'b1; exp_y = exq[0].yv; exp_ch = exq[0].ch; y_hold = exp_y;
        void'(exq.pop_front());
      end
      if (n == done_at) busy_exp = 1'b0;
      checks++;
      if (y_valid !== exp_v) begin
        errors++; $display("FAIL y_valid edge=%0d got=%b want=%b", n, y_valid, exp_v);
      end
      checks++;
      if (y !== exp_y) begin
        errors++; $display("FAIL y edge=%0d got=%h want=%h", n, y, exp_y);
      end
      if (exp_v) begin
        checks++;
        if (y_ch !== 2'(exp_ch)) begin
          errors++; $display("FAIL y_ch edge=%0d got=%0d want=%0d", n, y_ch, exp_ch);
        end
        obs_y[exp_ch] = y;
      end
      checks++;
      if (done_sig !== 1'(n == done_at)) begin
        errors++; $display("FAIL done_sig edge=%0d got=%b want=%b", n, done_sig, (n == done_at));
      end
      if (done_sig === 1'b1) done_seen++;
      checks++;
      if (busy !== busy_exp) begin
        errors++; $display("FAIL busy edge=%0d got=%b want=%b", n, busy, busy_exp);
      end
    end
    sta = 1'b0; x_valid = 1'b0; rst_user = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (y !== '0) begin errors++; $display("FAIL reset_y got=%h want=0", y); end
    checks++;
    if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid got=%b want=0", y_valid); end
    checks++;
    if (y_ch !== 2'd0) begin errors++; $display("FAIL reset_y_ch got=%0d want=0", y_ch); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++;
    if (done_sig !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done_sig); end
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    repeat (3) begin
      @(posedge clk);
      n++;
      #1;
      checks++;
      if (y_valid !== 1'b0 || done_sig !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle got vld=%b done=%b busy=%b want 0/0/0", y_valid, done_sig, busy);
      end
    end
  endtask

  task automatic test_single_frame();
    frame_t xs;
    xs = '{ONE_V, 0, 0, 0};
    clear_obs();
    done_seen = 0;
    run_frame(xs, 0, 1'b0, -1);
    checks++;
    if (obs_y[0] !== 32'h0000_C000) begin
      errors++; $display("FAIL single_ch0_y got=%h want=0000c000", obs_y[0]);
    end
    for (int c = 1; c < N; c++) begin
      checks++;
      if (obs_y[c] !== '0) begin errors++; $display("FAIL single_ch%0d_y got=%h want=0", c, obs_y[c]); end
    end
    checks++;
    if (done_seen != 1) begin errors++; $display("FAIL single_done_count got=%0d want=1", done_seen); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_windup();
    frame_t xs;
    logic [W-1:0] y_tab [6];
`ifdef PI_MC_ANTIWINDUP_EN
    y_tab = '{32'h0000_C000, 32'h0001_4000, 32'h0001_8000, 32'h0001_8000, 32'h0001_8000, 32'h0001_0000};
`else
    y_tab = '{32'h0000_C000, 32'h0001_4000, 32'h0001_8000, 32'h0001_8000, 32'h0001_8000, 32'h0001_8000};
`endif
    rst_user = 1'b1;
    @(posedge clk);
    n++;
    model_clear();
    #1 rst_user = 1'b0;
    for (int f = 0; f < 6; f++) begin
      xs = '{(f < 5) ? ONE_V : -ONE_V, 0, 0, 0};
      clear_obs();
      run_frame(xs, 1, 1'b0, -1);
      checks++;
      if (obs_y[0] !== y_tab[f]) begin
        errors++; $display("FAIL windup_frame%0d_y got=%h want=%h", f, obs_y[0], y_tab[f]);
      end
    end
  endtask

  task automatic test_user_abort();
    frame_t xs;
    xs = '{ONE_V, ONE_V, ONE_V, ONE_V};
    done_seen = 0;
    run_frame(xs, 0, 1'b0, 1);
    checks++;
    if (done_seen != 0) begin errors++; $display("FAIL abort_done_count got=%0d want=0", done_seen); end
    xs = '{ONE_V, 0, 0, 0};
    clear_obs();
    run_frame(xs, 2, 1'b0, -1);
    checks++;
    if (obs_y[0] !== 32'h0000_C000) begin
      errors++; $display("FAIL abort_next_ch0_y got=%h want=0000c000", obs_y[0]);
    end
  endtask

  task automatic test_random_frames();
    frame_t xs;
    done_seen = 0;
    for (int f = 0; f < 8; f++) begin
      for (int c = 0; c < N; c++) xs[c] = rand_x();
      run_frame(xs, 3, 1'b1, -1);
    end
    checks++;
    if (done_seen != 8) begin errors++; $display("FAIL random_done_count got=%0d want=8", done_seen); end
  endtask

  task automatic test_async_reset();
    frame_t xs;
    sta = 1'b1;
    @(posedge clk); n++;
    #1 sta = 1'b0; x_valid = 1'b1; x = 32'h0001_0000;
    @(posedge clk); n++;
    #1 x = 32'h0001_0000;
    @(posedge clk); n++;
    #1 x_valid = 1'b0;
    @(posedge clk); n++;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (y !== '0) begin errors++; $display("FAIL async_y got=%h want=0", y); end
    checks++;
    if (y_valid !== 1'b0) begin errors++; $display("FAIL async_y_valid got=%b want=0", y_valid); end
    checks++;
    if (y_ch !== 2'd0) begin errors++; $display("FAIL async_y_ch got=%0d want=0", y_ch); end
    checks++;
    if (busy !== 1'b0 || done_sig !== 1'b0) begin
      errors++; $display("FAIL async_ctrl got busy=%b done=%b want 0/0", busy, done_sig);
    end
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    exq.delete();
    done_at = -1; busy_exp = 1'b0; y_hold = '0;
    repeat (2) begin
      @(posedge clk); n++;
      #1;
      checks++;
      if (y_valid !== 1'b0 || done_sig !== 1'b0) begin
        errors++; $display("FAIL async_resume got vld=%b done=%b want 0/0", y_valid, done_sig);
      end
    end
    xs = '{ONE_V, 0, 0, 0};
    clear_obs();
    done_seen = 0;
    run_frame(xs, 0, 1'b0, -1);
    checks++;
    if (obs_y[0] !== 32'h0000_C000) begin
      errors++; $display("FAIL async_next_ch0_y got=%h want=0000c000", obs_y[0]);
    end
    checks++;
    if (done_seen != 1) begin errors++; $display("FAIL async_done_count got=%0d want=1", done_seen); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_windup();
    test_user_abort();
    test_random_frames();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached at edge %0d", n);
    $fatal(1, "watchdog");
  end

endmodule
